hamming_secded_pipe: RTL and testbench
======================================

// Module: hamming_secded_pipe
// PURPOSE
//  Parametrised, pipelined Hamming SECDED codec: encodes DATA_W-bit words, optionally injects 1- or 2-bit
//  faults, then decodes, corrects single errors and flags double errors. Streams over valid/ready.
//  Keeps saturating error counters. Generalises the 4-bit combinational Hamming(7,4) inject/correct cell.
// PARAMETERS
//  DATA_W  4  data width; legal 4, 11, 26 (perfect Hamming); other values -> elaboration $error
//  P       derived  parity bits: 3/4/5 for DATA_W 4/11/26; N = 2^P-1 code positions; position 0 = overall parity
//  CNT_W   8  width of each saturating error counter
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        synchronous, active-high reset
//  in_valid      in   1        input word valid
//  in_ready      out  1        block accepts word this cycle
//  in_data       in   DATA_W   data to encode
//  inj_en        in   1        inject fault at inj_pos_a (sampled with accepted word)
//  inj_dbl       in   1        also inject at inj_pos_b (needs inj_en)
//  inj_pos_a     in   P        codeword position 0..N to flip
//  inj_pos_b     in   P        second position; ignored if == inj_pos_a
//  out_valid     out  1        result valid
//  out_ready     in   1        downstream accepts result
//  out_data      out  DATA_W   corrected data (raw data bits if double error)
//  out_syndrome  out  P        Hamming syndrome (failing position, 0 = none in 1..N)
//  out_err_sgl   out  1        single error detected and corrected
//  out_err_dbl   out  1        uncorrectable double error detected
//  cnt_sgl       out  CNT_W    saturating count of delivered words with out_err_sgl
//  cnt_dbl       out  CNT_W    saturating count of delivered words with out_err_dbl
//  cnt_clr       in   1        synchronous clear of both counters
// BEHAVIOUR
//  - Codeword c[0..N]: parity p_k at position 2^k, data bits LSB-first into non-power-of-2 positions ascending;
//    p_k = XOR of positions with bit k set; c[0] = XOR of c[1..N] (even overall parity).
//  - Stage 1 (S1): encode + inject, registered. Stage 2 (S2): syndrome, overall check, correct, registered.
//  - Latency: word accepted in cycle t appears on out_* at t+2 when no backpressure; 1 word/cycle throughput.
//  - Handshake: transfer on valid&&ready. s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv;
//    in_ready = s1_adv (combinational from out_ready). out_* stable while out_valid && !out_ready.
//  - Decode: syn = XOR of indices of set bits in c[1..N]; op = XOR c[0..N].
//    syn==0,op==0: clean. op==1: single; flip position syn (syn==0 -> c[0], data unchanged); sgl=1.
//    syn!=0,op==0: double; dbl=1, data bits passed uncorrected. sgl and dbl never both 1.
//  - Counters increment once per delivered word (out_valid&&out_ready), saturate at 2^CNT_W-1;
//    cnt_clr wins over simultaneous increment.
//  - Reset: in_ready=0 during reset, 1 the cycle after; out_valid=0, out_data=0, out_syndrome=0,
//    out_err_sgl=0, out_err_dbl=0, cnt_sgl=0, cnt_dbl=0; in-flight words discarded (mid-stream reset drops S1/S2).
//  - inj_* sampled only on accepted cycles; inj_dbl with inj_pos_b==inj_pos_a behaves as single injection.
// CONFIGURATION
//  HAMMING_INJECT_EN defined: fault injection in S1 as above.
//  Undefined: inj_* ports present but ignored; no injection logic; codeword passes unmodified to S2.
// TESTING
//  DATA_W=4, in_data=4'hB, no inject, out_ready=1 -> out_data=4'hB, syn=0, sgl=0, dbl=0 at t+2.
//  in_data=4'hB, inj_en=1, pos_a=3 -> out_data=4'hB, syn=3, sgl=1, cnt_sgl=1.
//  in_data=4'h5, inj_en=1, pos_a=0 -> out_data=4'h5, syn=0, sgl=1 (overall-parity bit fault).
//  in_data=4'hB, inj_en=1, inj_dbl=1, pos_a=3, pos_b=5 -> dbl=1, syn=6, sgl=0, cnt_dbl=1.
//  out_ready=0 for 5 cycles, 4 words offered -> in_ready=0 after 2 accepted; release -> all 4 in order, none lost.
//  CNT_W=2, 5 single-error words -> cnt_sgl=3; cnt_clr with 6th error -> 0; reset mid-stream -> out_valid=0 next.

Source files
------------

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined Hamming SECDED codec with valid/ready streaming.
// Fault injection is compiled in only when HAMMING_INJECT_EN is defined.
module hamming_secded_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8,
  localparam int P = (DATA_W == 26) ? 5 :
                     (DATA_W == 11) ? 4 : 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic              inj_dbl,
  input  logic [P-1:0]      inj_pos_a,
  input  logic [P-1:0]      inj_pos_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_err_sgl,
  output logic              out_err_dbl,
  output logic [CNT_W-1:0]  cnt_sgl,
  output logic [CNT_W-1:0]  cnt_dbl,
  input  logic              cnt_clr
);

  localparam int N  = (1 << P) - 1;
  localparam int CW = N + 1;

  if (DATA_W != 4 && DATA_W != 11 && DATA_W != 26) begin : g_bad_width
    $error("hamming_secded_pipe: DATA_W must be 4, 11 or 26");
  end

  // Codeword position holding data bit j (non-power-of-2 slots, ascending).
  function automatic int dpos(input int j);
    int cnt;
    int r;
    cnt = 0;
    r   = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) r = p;
        cnt++;
      end
    end
    return r;
  endfunction

  // Positions 1..N whose index has bit k set.
  function automatic logic [CW-1:0] pmask(input int k);
    logic [CW-1:0] m;
    m = '0;
    for (int p = 1; p <= N; p++) begin
      if (((p >> k) & 1) != 0) m = m | (CW'(1) << p);
    end
    return m;
  endfunction

  logic          s1_valid;
  logic [CW-1:0] s1_cw;
  logic [CW-1:0] enc_cw;
  logic [CW-1:0] s1_next;
  logic          s1_adv;
  logic          s2_adv;

  logic [P-1:0]      syn;
  logic              op;
  logic [CW-1:0]     cw_fix;
  logic [DATA_W-1:0] dec;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !reset;

  // Encoder: scatter data, fill parity slots, then overall parity at c[0].
  always_comb begin
    enc_cw = '0;
    for (int j = 0; j < DATA_W; j++) begin
      enc_cw = enc_cw |
        ((CW'(in_data >> j) & CW'(1)) << dpos(j));
    end
    for (int k = 0; k < P; k++) begin
      enc_cw = enc_cw |
        (CW'(^(enc_cw & pmask(k))) << (1 << k));
    end
    enc_cw[0] = ^enc_cw[N:1];
  end

`ifdef HAMMING_INJECT_EN
  logic [CW-1:0] inj_mask;

  // OR-ing the two flips makes pos_b == pos_a a single fault.
  always_comb begin
    inj_mask = '0;
    if (inj_en) begin
      inj_mask = CW'(1) << inj_pos_a;
      if (inj_dbl) inj_mask = inj_mask | (CW'(1) << inj_pos_b);
    end
  end

  assign s1_next = enc_cw ^ inj_mask;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_dbl, inj_pos_a, inj_pos_b};
  assign s1_next    = enc_cw;
`endif

  // Stage 1 register: encoded (and possibly faulted) codeword.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_cw <= s1_next;
    end
  end

  // Decoder: syndrome, overall parity, correction and data gather.
  always_comb begin
    syn = '0;
    for (int k = 0; k < P; k++) begin
      syn = syn | (P'(^(s1_cw & pmask(k))) << k);
    end
    op     = ^s1_cw;
    cw_fix = op ? (s1_cw ^ (CW'(1) << syn)) : s1_cw;
    dec    = '0;
    for (int j = 0; j < DATA_W; j++) begin
      dec = dec |
        (DATA_W'((cw_fix >> dpos(j)) & CW'(1)) << j);
    end
  end

  // Stage 2 register: held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err_sgl  <= 1'b0;
      out_err_dbl  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= dec;
        out_syndrome <= syn;
        out_err_sgl  <= op;
        out_err_dbl  <= !op && (syn != '0);
      end
    end
  end

  // Saturating error counters on delivered words; clear wins.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_sgl <= '0;
      cnt_dbl <= '0;
    end else if (out_valid && out_ready) begin
      if (out_err_sgl && cnt_sgl != '1)
        cnt_sgl <= cnt_sgl + CNT_W'(1);
      if (out_err_dbl && cnt_dbl != '1)
        cnt_dbl <= cnt_dbl + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Scoreboard bench for hamming_secded_pipe (DATA_W=4, CNT_W=2).
// Injection expectations apply only when HAMMING_INJECT_EN is defined.
module tb_hamming_secded_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       inj_en;
  logic       inj_dbl;
  logic [2:0] inj_pos_a;
  logic [2:0] inj_pos_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_err_sgl;
  logic       out_err_dbl;
  logic [1:0] cnt_sgl;
  logic [1:0] cnt_dbl;
  logic       cnt_clr;

  hamming_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .inj_en(inj_en), .inj_dbl(inj_dbl),
    .inj_pos_a(inj_pos_a), .inj_pos_b(inj_pos_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome),
    .out_err_sgl(out_err_sgl), .out_err_dbl(out_err_dbl),
    .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    bit         ie;
    bit         id;
    logic [2:0] pa;
    logic [2:0] pb;
    logic [3:0] ed;
    logic [2:0] es;
    bit         esgl;
    bit         edbl;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    bit         sgl;
    bit         dbl;
  } exp_t;

  // Expected values assume injection is active.
  vec_t vt[11] = '{
    '{4'hB, 0, 0, 3'd0, 3'd0, 4'hB, 3'd0, 0, 0},
    '{4'hB, 1, 0, 3'd3, 3'd0, 4'hB, 3'd3, 1, 0},
    '{4'h5, 1, 0, 3'd0, 3'd0, 4'h5, 3'd0, 1, 0},
    '{4'hB, 1, 1, 3'd3, 3'd5, 4'h8, 3'd6, 0, 1},
    '{4'h0, 1, 0, 3'd7, 3'd0, 4'h0, 3'd7, 1, 0},
    '{4'h6, 1, 0, 3'd6, 3'd0, 4'h6, 3'd6, 1, 0},
    '{4'hF, 1, 1, 3'd1, 3'd2, 4'hF, 3'd3, 0, 1},
    '{4'hA, 1, 1, 3'd4, 3'd4, 4'hA, 3'd4, 1, 0},
    '{4'h7, 0, 0, 3'd0, 3'd0, 4'h7, 3'd0, 0, 0},
    '{4'h3, 1, 1, 3'd0, 3'd7, 4'hB, 3'd7, 0, 1},
    '{4'h9, 0, 1, 3'd3, 3'd5, 4'h9, 3'd0, 0, 0}
  };

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  bit   started = 0;
  int   m_sgl = 0;
  int   m_dbl = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
`ifdef HAMMING_INJECT_EN
    e = '{v.ed, v.es, v.esgl, v.edbl};
`else
    e = '{v.d, 3'd0, 1'b0, 1'b0};
`endif
    return e;
  endfunction

  task automatic send(input vec_t v);
    bit ok;
    in_valid  = 1'b1;
    in_data   = v.d;
    inj_en    = v.ie;
    inj_dbl   = v.id;
    inj_pos_a = v.pa;
    inj_pos_b = v.pb;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      q.push_back(expect_of(v));
      acc_cnt++;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    inj_en   = 1'b0;
    inj_dbl  = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: counter model, scoreboard pops, stall stability.
  logic [3:0] h_d;
  logic [2:0] h_s;
  logic       h_sg;
  logic       h_db;
  bit         was_stall = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("cnt_sgl", cnt_sgl, m_sgl);
      chk("cnt_dbl", cnt_dbl, m_dbl);
      if (!reset && out_valid && !out_ready) begin
        if (was_stall) begin
          chk("stall_data", out_data, h_d);
          chk("stall_syn", out_syndrome, h_s);
          chk("stall_flags", {out_err_sgl, out_err_dbl}, {h_sg, h_db});
        end
        h_d = out_data;
        h_s = out_syndrome;
        h_sg = out_err_sgl;
        h_db = out_err_dbl;
        was_stall = 1;
      end else begin
        was_stall = 0;
      end
      if (reset || cnt_clr) begin
        m_sgl = 0;
        m_dbl = 0;
      end
      if (!reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_syndrome", out_syndrome, e.s);
          chk("out_err_sgl", out_err_sgl, e.sgl);
          chk("out_err_dbl", out_err_dbl, e.dbl);
          if (!cnt_clr) begin
            if (e.sgl && m_sgl < 3) m_sgl++;
            if (e.dbl && m_dbl < 3) m_dbl++;
          end
        end
      end
    end
  end

  int exp_sat;

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    in_data = '0;
    inj_pos_a = '0;
    inj_pos_b = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_syn", out_syndrome, 0);
    chk("rst_flags", {out_err_sgl, out_err_dbl}, 0);
    chk("rst_cnt", {cnt_sgl, cnt_dbl}, 0);
    started = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Latency: two edges from acceptance to out_valid.
    @(posedge clk);
    #1;
    send(vt[0]);
    idle();
    @(negedge clk);
    chk("lat_s1", out_valid, 0);
    @(negedge clk);
    chk("lat_s2", out_valid, 1);
    drain();

    // Directed table, back to back.
    for (int i = 0; i < 11; i++) send(vt[i]);
    idle();
    drain();

    // Counter saturation with CNT_W=2.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    send(vt[1]);
    send(vt[2]);
    send(vt[4]);
    send(vt[5]);
    send(vt[7]);
    idle();
    drain();
`ifdef HAMMING_INJECT_EN
    exp_sat = 3;
`else
    exp_sat = 0;
`endif
    @(negedge clk);
    chk("cnt_sat", cnt_sgl, exp_sat);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    send(vt[1]);
    idle();
    drain();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_win", cnt_sgl, 0);
    @(posedge clk);
    #1;

    // Backpressure: 4 offered, 2 accepted, all delivered in order.
    acc_cnt = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vt[i]);
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total", acc_cnt, 4);

    // Mid-stream reset drops in-flight words.
    send(vt[3]);
    send(vt[8]);
    idle();
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid2", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(vt[5]);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
